// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the 8x8 LED matrix scanner.
package led_matrix_pkg;

    localparam int N_ROWS = 8;
    localparam int N_COLS = 8;

    typedef logic [N_ROWS-1:0] row_t;
    typedef logic [N_COLS-1:0] col_t;

    // True when exactly one bit of v is set.
    function automatic logic onehot_valid(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'd1)) == 8'h00);
    endfunction

endpackage

// File: rtl/led_matrix_scan_if.sv
// Cursor/edit inputs and matrix drive outputs of the LED matrix scanner.
interface led_matrix_scan_if;
    import led_matrix_pkg::*;

    row_t cur_row;     // one-hot cursor row
    col_t cur_col;     // one-hot cursor column
    logic mark;        // toggle the pixel under the cursor
    logic clear;       // zero the whole frame buffer
    row_t scan_row;    // row enable to the matrix
    col_t scan_col;    // column data for the enabled row
    logic frame_tick;  // one pulse per completed frame

    modport master (
        output cur_row, cur_col, mark, clear,
        input  scan_row, scan_col, frame_tick
    );

    modport slave (
        input  cur_row, cur_col, mark, clear,
        output scan_row, scan_col, frame_tick
    );

endinterface

// File: rtl/led_matrix_scan_mod_counter.sv
// Modulo-MOD up counter with enable; tc flags the enabled step that wraps to zero.
module mod_counter #(
    parameter int MOD = 4,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    // Wrap event: enabled while sitting on the last value, so chained counters step together.
    assign tc = en && (count == LAST);

    // Count up while enabled, returning to zero after MOD-1.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values and chained counters stay in step.
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/led_matrix_scan.sv
// Row-multiplexed driver for an 8x8 LED matrix with a paintable frame buffer
// and a blinking cursor overlay. All matrix outputs are registered.
module led_matrix_scan
    import led_matrix_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,  // clk cycles per row slot
    parameter int BLANK        = 2,     // leading blanked cycles of each slot
    parameter int BLINK_FRAMES = 32     // frames per blink half-period
) (
    input logic              clk,
    input logic              reset,
    led_matrix_scan_if.slave bus
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK);

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       row_idx;
    logic [FRM_W-1:0] frame_cnt;
    logic             div_tc;     // last cycle of a row slot
    logic             row_tc;     // last cycle of a frame (row 7 wraps to 0)
    logic             frame_tc;   // last cycle of a blink half-period
    logic             blink_on;
    col_t             fb [N_ROWS];
    logic             cursor_ok;
    col_t             ovl;

    mod_counter #(.MOD(SCAN_DIV), .W(DIV_W)) u_div (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .count (div_cnt),
        .tc    (div_tc)
    );

    mod_counter #(.MOD(N_ROWS), .W(3)) u_row (
        .clk   (clk),
        .reset (reset),
        .en    (div_tc),
        .count (row_idx),
        .tc    (row_tc)
    );

    mod_counter #(.MOD(BLINK_FRAMES), .W(FRM_W)) u_frame (
        .clk   (clk),
        .reset (reset),
        .en    (row_tc),
        .count (frame_cnt),
        .tc    (frame_tc)
    );

    // The frame count is only observed through its terminal count.
    wire unused_frame = &{1'b0, frame_cnt};

    // Blink phase flips each time the frame counter wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_on <= 1'b1;
        end else if (frame_tc) begin
            blink_on <= ~blink_on;
        end
    end

    // Cursor overlay for the row currently being scanned.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        ovl       = '0;
        cursor_ok = onehot_valid(bus.cur_row) && onehot_valid(bus.cur_col);
        if (blink_on && cursor_ok && bus.cur_row[row_idx]) begin
            ovl = bus.cur_col;
        end
    end

    // Frame buffer edits: clear beats mark; mark toggles the cursor pixel.
    always_ff @(posedge clk) begin
        // NOTE: the buffer is a small flop array, so it is reset explicitly like any other state.
        if (reset || bus.clear) begin
            for (int i = 0; i < N_ROWS; i++) begin
                fb[i] <= '0;
            end
        end else if (bus.mark && cursor_ok) begin
            for (int i = 0; i < N_ROWS; i++) begin
                if (bus.cur_row[i]) begin
                    fb[i] <= fb[i] ^ bus.cur_col;
                end
            end
        end
    end

    // Registered matrix drive and end-of-frame pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.scan_row   <= '0;
            bus.scan_col   <= '0;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.scan_row   <= row_t'(1) << row_idx;
            bus.scan_col   <= (div_cnt < BLANK_END) ? '0 : (fb[row_idx] ^ ovl);
            bus.frame_tick <= row_tc;
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan with SCAN_DIV=4, BLANK=1, BLINK_FRAMES=2.
// Timing: slot = 4 cycles, frame = 32 cycles, blink half-period = 64 cycles.
module tb_led_matrix_scan;
    import led_matrix_pkg::*;

    logic clk = 1'b0;
    logic reset;

    led_matrix_scan_if bus();

    led_matrix_scan #(
        .SCAN_DIV     (4),
        .BLANK        (1),
        .BLINK_FRAMES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    int   n           = 0;   // clock edges since reset was released
    col_t fb_m [N_ROWS];     // expected frame buffer contents

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got %02h, want %02h (edge %0d)", tag, observed, expected, n);
        end
    endtask

    function automatic bit one_hot(input logic [7:0] v);
        return $countones(v) == 1;
    endfunction

    // One clock: predict the registered outputs from the pre-edge state, apply the edit, compare.
    task automatic tick();
        logic [7:0] e_row, e_col, e_tick, ovl;
        int r, d;
        bit lit, ok;
        ok = one_hot(bus.cur_row) && one_hot(bus.cur_col);
        if (reset) begin
            e_row = 8'h00; e_col = 8'h00; e_tick = 8'h00;
        end else begin
            r     = (n / 4) % 8;
            d     = n % 4;
            lit   = ((n / 64) % 2) == 0;
            e_row = 8'h01 << r;
            ovl   = (lit && ok && bus.cur_row[r]) ? bus.cur_col : 8'h00;
            e_col = (d < 1) ? 8'h00 : (fb_m[r] ^ ovl);
            e_tick = (n % 32 == 31) ? 8'h01 : 8'h00;
        end
        @(posedge clk);
        #1;
        if (reset || bus.clear) begin
            for (int i = 0; i < N_ROWS; i++) fb_m[i] = 8'h00;
        end else if (bus.mark && ok) begin
            for (int i = 0; i < N_ROWS; i++) if (bus.cur_row[i]) fb_m[i] = fb_m[i] ^ bus.cur_col;
        end
        n = reset ? 0 : n + 1;
        check("scan_row", bus.scan_row, e_row);
        check("scan_col", bus.scan_col, e_col);
        check("frame_tick", {7'b0, bus.frame_tick}, e_tick);
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic run_to(input int target);
        while (n < target) tick();
    endtask

    task automatic pulse_mark();
        bus.mark = 1'b1;
        tick();
        bus.mark = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        bus.cur_row = 8'h00;
        bus.cur_col = 8'h00;
        bus.mark    = 1'b0;
        bus.clear   = 1'b0;
        for (int i = 0; i < N_ROWS; i++) fb_m[i] = 8'h00;

        // Reset state
        run(3);
        check("rst_row", bus.scan_row, 8'h00);
        check("rst_col", bus.scan_col, 8'h00);

        // Release: row enable walks 01..80 with an empty buffer
        reset = 1'b0;
        tick();
        check("first_row", bus.scan_row, 8'h01);
        run_to(32);
        check("frame_tick_32", {7'b0, bus.frame_tick}, 8'h01);
        check("last_row", bus.scan_row, 8'h80);
        tick();
        check("row_wrap", bus.scan_row, 8'h01);

        // Cursor at row 2, column 5: blank cycle then 20 for three cycles
        bus.cur_row = 8'h04;
        bus.cur_col = 8'h20;
        run_to(41);
        check("cur_blank_row", bus.scan_row, 8'h04);
        check("cur_blank_col", bus.scan_col, 8'h00);
        tick();
        check("cur_lit_col", bus.scan_col, 8'h20);
        run_to(64);
        check("frame_tick_64", {7'b0, bus.frame_tick}, 8'h01);
        run_to(74);
        check("blink_off", bus.scan_col, 8'h00);
        run_to(138);
        check("blink_back", bus.scan_col, 8'h20);

        // Mark under the cursor: lit slot shows fb^ovl=00, dark slot shows 20
        pulse_mark();
        run_to(170);
        check("mark_lit", bus.scan_col, 8'h00);
        run_to(202);
        check("mark_dark", bus.scan_col, 8'h20);

        // Second mark toggles the pixel back off
        pulse_mark();
        run_to(234);
        check("unmark_dark", bus.scan_col, 8'h00);
        run_to(266);
        check("unmark_lit", bus.scan_col, 8'h20);

        // Invalid cursors: no overlay, mark ignored
        bus.cur_row = 8'h06;
        pulse_mark();
        run(40);
        bus.cur_row = 8'h04;
        bus.cur_col = 8'h00;
        pulse_mark();
        run(40);

        // Paint row 0 full, then view it with no cursor
        bus.cur_row = 8'h01;
        for (int j = 0; j < N_COLS; j++) begin
            bus.cur_col = 8'h01 << j;
            pulse_mark();
        end
        bus.cur_col = 8'h00;
        run(36);

        // Mark held three cycles toggles three times
        bus.cur_row = 8'h08;
        bus.cur_col = 8'h01;
        bus.mark    = 1'b1;
        run(3);
        bus.mark    = 1'b0;
        bus.cur_col = 8'h00;
        run(36);

        // Clear and mark together: clear wins
        bus.cur_row = 8'h01;
        bus.cur_col = 8'h01;
        bus.clear   = 1'b1;
        bus.mark    = 1'b1;
        tick();
        bus.clear   = 1'b0;
        bus.mark    = 1'b0;
        bus.cur_col = 8'h00;
        run(36);

        // Repaint a pixel, then reset mid-slot at row 5, div_cnt 2
        bus.cur_row = 8'h08;
        bus.cur_col = 8'h10;
        pulse_mark();
        bus.cur_col = 8'h00;
        while ((n % 32) != 22) tick();
        reset = 1'b1;
        tick();
        check("rst_mid_row", bus.scan_row, 8'h00);
        check("rst_mid_col", bus.scan_col, 8'h00);
        reset = 1'b0;
        tick();
        check("rst_mid_next_row", bus.scan_row, 8'h01);
        run(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
